// File: rtl/axi_lite_reg_master.sv
// Single-outstanding AXI4-Lite initiator for the *_cpu_regs slaves: one command in, one response out.
// Optional bus watchdog enabled by defining AXIL_MASTER_TIMEOUT_EN.
module axi_lite_reg_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDRESS = '0,
  parameter int C_TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_rnw,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            busy,
  output logic                            timeout_err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  // state     | meaning
  // S_IDLE    | waiting for a command
  // S_WR      | AW and W channels in flight, each retires on its own handshake
  // S_WR_RESP | waiting for BVALID
  // S_RD_ADDR | AR in flight
  // S_RD_DATA | waiting for RVALID
  // S_RSP     | response held until rsp_ready
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;
  localparam logic [2:0] S_RSP     = 3'd5;

  logic [2:0]                      state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                            aw_done_q, aw_done_d;
  logic                            w_done_q, w_done_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]                      resp_q, resp_d;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int TW = (C_TIMEOUT_CYCLES > 2) ? $clog2(C_TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LIMIT = TW'(C_TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          timeout_err_q, timeout_err_d;
  logic          waiting;
`endif

  assign cmd_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign rsp_valid     = (state_q == S_RSP);
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_AWVALID = (state_q == S_WR) && !aw_done_q;
  assign M_AXI_WVALID  = (state_q == S_WR) && !w_done_q;
  assign M_AXI_BREADY  = (state_q == S_WR_RESP);
  assign M_AXI_ARVALID = (state_q == S_RD_ADDR);
  assign M_AXI_RREADY  = (state_q == S_RD_DATA);

  assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;
  assign b_hs  = M_AXI_BREADY && M_AXI_BVALID;
  assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
  assign r_hs  = M_AXI_RREADY && M_AXI_RVALID;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    case (state_q)
      S_IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (cmd_valid) begin
          addr_d  = cmd_addr ^ C_BASE_ADDRESS;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          state_d = cmd_rnw ? S_RD_ADDR : S_WR;
        end
      end
      S_WR: begin
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (M_AXI_BVALID) begin
          resp_d  = M_AXI_BRESP;
          rdata_d = '0;
          state_d = S_RSP;
        end
      end
      S_RD_ADDR: begin
        if (M_AXI_ARREADY) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (M_AXI_RVALID) begin
          rdata_d = M_AXI_RDATA;
          resp_d  = M_AXI_RRESP;
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef AXIL_MASTER_TIMEOUT_EN
    // Watchdog counts idle-bus cycles in the four bus-wait states; the abort wins over a late handshake.
    waiting       = (state_q == S_WR) || (state_q == S_WR_RESP) ||
                    (state_q == S_RD_ADDR) || (state_q == S_RD_DATA);
    timeout_err_d = 1'b0;
    tmo_cnt_d     = '0;
    if (waiting) begin
      if (!(aw_hs || w_hs || b_hs || ar_hs || r_hs)) tmo_cnt_d = tmo_cnt_q + 1'b1;
      if (tmo_cnt_q == TMO_LIMIT) begin
        state_d       = S_RSP;
        resp_d        = 2'b11;
        rdata_d       = C_M_AXI_DATA_WIDTH'(32'hDEADBEEF);
        aw_done_d     = 1'b0;
        w_done_d      = 1'b0;
        tmo_cnt_d     = '0;
        timeout_err_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

`ifdef AXIL_MASTER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_lite_reg_master.sv
// Bench for axi_lite_reg_master: directed command table against a latency-configurable register slave.
module tb_axi_lite_reg_master;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_rnw;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy, timeout_err;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  always #5 clk = ~clk;

  axi_lite_reg_master #(
    .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32),
    .C_BASE_ADDRESS(32'h4000_0000), .C_TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .busy(busy), .timeout_err(timeout_err),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  // ---------------- slave model: 4 RW regs at 0x0-0xC, write counter (read-clear) at 0x10,
  // SLVERR at 0x20, everything else reads 0xDEADBEEF; wrong upper address bits give DECERR.
  int aw_lat, w_lat, b_lat, ar_lat, r_lat;
  int aw_wait, w_wait, ar_wait, b_cnt, r_cnt;
  int aw_hs_cnt = 0, w_hs_cnt = 0, ar_hs_cnt = 0;
  int stab_aw = 0, stab_w = 0, stab_ar = 0, overlap_err = 0;
  int tmo_pulses = 0;
  logic [31:0] mem [0:3] = '{32'h0, 32'h0, 32'h0, 32'h0};
  logic [31:0] wr_cnt = 32'h0;
  logic        got_aw, got_w, b_pend, r_pend, aw_hold, w_hold, ar_hold;
  logic [31:0] s_awaddr, s_wdata, s_araddr, aw_prev, ar_prev;
  logic [35:0] w_prev;
  logic [3:0]  s_wstrb;

  assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_wait >= aw_lat);
  assign M_AXI_WREADY  = M_AXI_WVALID && (w_wait >= w_lat);
  assign M_AXI_ARREADY = M_AXI_ARVALID && (ar_wait >= ar_lat);

  function automatic logic [33:0] rd_dec(input logic [31:0] a);
    if (a[31:12] != 20'h40000) return {2'b11, 32'h0};
    case (a[11:0])
      12'h000, 12'h004, 12'h008, 12'h00C: return {2'b00, mem[a[3:2]]};
      12'h010: return {2'b00, wr_cnt};
      12'h020: return {2'b10, 32'h0};
      default: return {2'b00, 32'hDEADBEEF};
    endcase
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_cnt <= 0; r_cnt <= 0;
      got_aw <= 1'b0; got_w <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      M_AXI_BVALID <= 1'b0; M_AXI_RVALID <= 1'b0; M_AXI_BRESP <= 2'b00;
      M_AXI_RRESP <= 2'b00; M_AXI_RDATA <= 32'h0;
      aw_hold <= 1'b0; w_hold <= 1'b0; ar_hold <= 1'b0;
    end else begin
      aw_wait <= (M_AXI_AWVALID && !M_AXI_AWREADY) ? aw_wait + 1 : 0;
      w_wait  <= (M_AXI_WVALID && !M_AXI_WREADY) ? w_wait + 1 : 0;
      ar_wait <= (M_AXI_ARVALID && !M_AXI_ARREADY) ? ar_wait + 1 : 0;
      if (aw_hold && (!M_AXI_AWVALID || M_AXI_AWADDR != aw_prev)) stab_aw <= stab_aw + 1;
      if (w_hold && (!M_AXI_WVALID || {M_AXI_WSTRB, M_AXI_WDATA} != w_prev)) stab_w <= stab_w + 1;
      if (ar_hold && (!M_AXI_ARVALID || M_AXI_ARADDR != ar_prev)) stab_ar <= stab_ar + 1;
      aw_hold <= M_AXI_AWVALID && !M_AXI_AWREADY;
      w_hold  <= M_AXI_WVALID && !M_AXI_WREADY;
      ar_hold <= M_AXI_ARVALID && !M_AXI_ARREADY;
      aw_prev <= M_AXI_AWADDR;
      w_prev  <= {M_AXI_WSTRB, M_AXI_WDATA};
      ar_prev <= M_AXI_ARADDR;
      if ((M_AXI_AWVALID || M_AXI_WVALID || M_AXI_BREADY) && (M_AXI_ARVALID || M_AXI_RREADY))
        overlap_err <= overlap_err + 1;
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        got_aw <= 1'b1; s_awaddr <= M_AXI_AWADDR; aw_hs_cnt <= aw_hs_cnt + 1;
      end
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        got_w <= 1'b1; s_wdata <= M_AXI_WDATA; s_wstrb <= M_AXI_WSTRB; w_hs_cnt <= w_hs_cnt + 1;
      end
      if (got_aw && got_w) begin
        got_aw <= 1'b0; got_w <= 1'b0;
        if (s_awaddr[31:12] != 20'h40000) M_AXI_BRESP <= 2'b11;
        else if (s_awaddr[11:0] < 12'h010 && s_awaddr[1:0] == 2'b00) begin
          for (int b = 0; b < 4; b++)
            if (s_wstrb[b]) mem[s_awaddr[3:2]][8*b +: 8] <= s_wdata[8*b +: 8];
          wr_cnt <= wr_cnt + 1;
          M_AXI_BRESP <= 2'b00;
        end else if (s_awaddr[11:0] == 12'h020) M_AXI_BRESP <= 2'b10;
        else M_AXI_BRESP <= 2'b00;
        if (b_lat == 0) M_AXI_BVALID <= 1'b1;
        else begin b_pend <= 1'b1; b_cnt <= b_lat - 1; end
      end
      if (b_pend) begin
        if (b_cnt == 0) begin M_AXI_BVALID <= 1'b1; b_pend <= 1'b0; end
        else b_cnt <= b_cnt - 1;
      end
      if (M_AXI_BVALID && M_AXI_BREADY) M_AXI_BVALID <= 1'b0;
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        ar_hs_cnt <= ar_hs_cnt + 1;
        if (r_lat == 0) begin
          {M_AXI_RRESP, M_AXI_RDATA} <= rd_dec(M_AXI_ARADDR);
          if (M_AXI_ARADDR == 32'h4000_0010) wr_cnt <= 32'h0;
          M_AXI_RVALID <= 1'b1;
        end else begin
          r_pend <= 1'b1; r_cnt <= r_lat - 1; s_araddr <= M_AXI_ARADDR;
        end
      end
      if (r_pend) begin
        if (r_cnt == 0) begin
          {M_AXI_RRESP, M_AXI_RDATA} <= rd_dec(s_araddr);
          if (s_araddr == 32'h4000_0010) wr_cnt <= 32'h0;
          M_AXI_RVALID <= 1'b1;
          r_pend <= 1'b0;
        end else r_cnt <= r_cnt - 1;
      end
      if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RVALID <= 1'b0;
    end
  end

  always @(negedge clk) if (timeout_err === 1'b1) tmo_pulses <= tmo_pulses + 1;

  // ---------------- checking
  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_cmd(input string nm, input logic rnw, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb, input int hold,
                        output logic [31:0] rd, output logic [1:0] rs, output int lat,
                        output logic fa, output logic fw, output logic arv_at_rsp);
    logic got;
    int   bad;
    @(negedge clk);
    cmd_rnw = rnw; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb; cmd_valid = 1'b1;
    chk({nm, "_cmd_ready"}, {31'h0, cmd_ready}, 32'h1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0; got = 1'b0; fa = 1'b0; fw = 1'b0; rd = 32'h0; rs = 2'b00; arv_at_rsp = 1'b0;
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin fa = M_AXI_AWVALID; fw = M_AXI_WVALID; end
      if (rsp_valid) begin
        got = 1'b1; rd = rsp_rdata; rs = rsp_resp; arv_at_rsp = M_AXI_ARVALID;
      end
    end
    if (!got) begin
      chk({nm, "_rsp_seen"}, 32'h0, 32'h1);
    end else begin
      bad = 0;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_resp !== rs || cmd_ready !== 1'b0) bad++;
        cmd_rnw = 1'b1; cmd_addr = 32'h0000_0004; cmd_valid = 1'b1;
      end
      if (hold > 0) chk({nm, "_hold_stable"}, bad, 32'h0);
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      chk({nm, "_rsp_drop"}, {31'h0, rsp_valid}, 32'h0);
    end
  endtask

  typedef struct {
    logic        rnw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          aw_l, w_l, b_l, ar_l, r_l;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    int          exp_lat;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs;
    int          lat, a0, w0, r0;
    logic        fa, fw, arv;

    vecs[0]  = '{1'b0, 32'h004, 32'hA5A5_5A5A, 4'hF, 0, 0, 0, 0, 0, 32'h0, 2'b00, 4};
    vecs[1]  = '{1'b1, 32'h004, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'hA5A5_5A5A, 2'b00, 3};
    vecs[2]  = '{1'b1, 32'hFFC, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 2'b00, 3};
    vecs[3]  = '{1'b0, 32'h008, 32'h1122_3344, 4'b0101, 0, 3, 0, 0, 0, 32'h0, 2'b00, 7};
    vecs[4]  = '{1'b1, 32'h008, 32'h0, 4'h0, 0, 0, 0, 0, 2, 32'h0022_0044, 2'b00, 5};
    vecs[5]  = '{1'b1, 32'h010, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'h2, 2'b00, 3};
    vecs[6]  = '{1'b1, 32'h010, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'h0, 2'b00, 3};
    vecs[7]  = '{1'b0, 32'h020, 32'h5555_AAAA, 4'hF, 0, 0, 0, 0, 0, 32'h0, 2'b10, 4};
    vecs[8]  = '{1'b1, 32'h020, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'h0, 2'b10, 3};
    vecs[9]  = '{1'b0, 32'h000, 32'hFFFF_FFFF, 4'h0, 2, 2, 1, 0, 0, 32'h0, 2'b00, 7};
    vecs[10] = '{1'b1, 32'h000, 32'h0, 4'h0, 0, 0, 0, 1, 0, 32'h0, 2'b00, 4};
    vecs[11] = '{1'b1, 32'h010, 32'h0, 4'h0, 0, 0, 0, 0, 0, 32'h1, 2'b00, 3};

    cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
    rsp_ready = 1'b0;
    aw_lat = 0; w_lat = 0; b_lat = 0; ar_lat = 0; r_lat = 0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready_busy", {30'h0, cmd_ready, busy}, 32'h2);
    chk("reset_valids", {26'h0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                         M_AXI_RREADY, rsp_valid}, 32'h0);
    chk("reset_rsp", {rsp_rdata[31:2], rsp_resp ^ rsp_rdata[1:0]}, 32'h0);
    chk("reset_tmo", {31'h0, timeout_err}, 32'h0);
    resetn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      aw_lat = vecs[i].aw_l; w_lat = vecs[i].w_l; b_lat = vecs[i].b_l;
      ar_lat = vecs[i].ar_l; r_lat = vecs[i].r_l;
      a0 = aw_hs_cnt; w0 = w_hs_cnt; r0 = ar_hs_cnt;
      do_cmd($sformatf("v%0d", i), vecs[i].rnw, vecs[i].addr, vecs[i].wdata, vecs[i].strb, 0,
             rd, rs, lat, fa, fw, arv);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_resp", i), {30'h0, rs}, {30'h0, vecs[i].exp_resp});
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_first_aw_w", i), {30'h0, fa, fw}, vecs[i].rnw ? 32'h0 : 32'h3);
      chk($sformatf("v%0d_aw_w_count", i), {aw_hs_cnt[15:0] - a0[15:0], w_hs_cnt[15:0] - w0[15:0]},
          vecs[i].rnw ? 32'h0 : 32'h0001_0001);
      chk($sformatf("v%0d_ar_count", i), ar_hs_cnt - r0, vecs[i].rnw ? 32'h1 : 32'h0);
    end

    // response back-pressure: held 10 cycles while a new command is offered
    aw_lat = 0; w_lat = 0; b_lat = 0; ar_lat = 0; r_lat = 0;
    a0 = aw_hs_cnt; r0 = ar_hs_cnt;
    do_cmd("hold", 1'b0, 32'h00C, 32'hCAFE_F00D, 4'hF, 10, rd, rs, lat, fa, fw, arv);
    chk("hold_resp", {30'h0, rs}, 32'h0);
    chk("hold_counts", {aw_hs_cnt[15:0] - a0[15:0], ar_hs_cnt[15:0] - r0[15:0]}, 32'h0001_0000);
    do_cmd("hold_rb", 1'b1, 32'h00C, 32'h0, 4'h0, 0, rd, rs, lat, fa, fw, arv);
    chk("hold_rb_rdata", rd, 32'hCAFE_F00D);

    // reset while the write is stalled on AW/W
    aw_lat = 6; w_lat = 6;
    a0 = aw_hs_cnt;
    @(negedge clk);
    cmd_rnw = 1'b0; cmd_addr = 32'h000; cmd_wdata = 32'h1234_5678; cmd_wstrb = 4'hF;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", {30'h0, busy, M_AXI_AWVALID}, 32'h3);
    resetn = 1'b0;
    @(negedge clk);
    chk("rst_mid_idle", {24'h0, busy, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                         M_AXI_RREADY, rsp_valid, cmd_ready}, 32'h1);
    chk("rst_mid_rsp", rsp_rdata | {30'h0, rsp_resp}, 32'h0);
    resetn = 1'b1;
    lat = 0;
    repeat (8) begin @(negedge clk); if (rsp_valid !== 1'b0 || busy !== 1'b0) lat++; end
    chk("rst_no_rsp", lat, 32'h0);
    chk("rst_no_aw", aw_hs_cnt - a0, 32'h0);
    aw_lat = 0; w_lat = 0;
    do_cmd("rst_rb", 1'b1, 32'h000, 32'h0, 4'h0, 0, rd, rs, lat, fa, fw, arv);
    chk("rst_rb_rdata", rd, 32'h0);

`ifdef AXIL_MASTER_TIMEOUT_EN
    ar_lat = 1000;
    r0 = ar_hs_cnt;
    do_cmd("tmo", 1'b1, 32'h004, 32'h0, 4'h0, 0, rd, rs, lat, fa, fw, arv);
    chk("tmo_rdata", rd, 32'hDEAD_BEEF);
    chk("tmo_resp", {30'h0, rs}, 32'h3);
    chk("tmo_latency", lat, 32'd17);
    chk("tmo_arvalid", {31'h0, arv}, 32'h0);
    chk("tmo_no_ar", ar_hs_cnt - r0, 32'h0);
    chk("tmo_pulses", tmo_pulses, 32'h1);
    ar_lat = 0;
    do_cmd("tmo_after", 1'b1, 32'h004, 32'h0, 4'h0, 0, rd, rs, lat, fa, fw, arv);
    chk("tmo_after_rdata", rd, 32'hA5A5_5A5A);
`else
    chk("tmo_pulses", tmo_pulses, 32'h0);
`endif

    chk("stable_aw", stab_aw, 32'h0);
    chk("stable_w", stab_w, 32'h0);
    chk("stable_ar", stab_ar, 32'h0);
    chk("rd_wr_overlap", overlap_err, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "time limit");
  end

endmodule
